// File: rtl/i2c_defs.sv
// Shared I2C definitions: bus-phase encoding and default target address.
package i2c_defs;

    localparam logic [6:0] SLAVE_ADDR_DEF    = 7'h68;
    localparam logic [7:0] SLAVE_ADDR_PLUS_W = {SLAVE_ADDR_DEF, 1'b0};
    localparam logic [7:0] SLAVE_ADDR_PLUS_R = {SLAVE_ADDR_DEF, 1'b1};

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG_ADDR,
        REG_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK
    } bus_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchroniser for SCL/SDA with a history stage for edge,
// START and STOP detection.
module i2c_bus_sync (
    input  logic clk_200khz,
    input  logic rst,
    input  logic scl,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [2:0] scl_q;
    logic [2:0] sda_q;

    // Idle bus is high, so reset to ones to avoid phantom edges.
    always_ff @(posedge clk_200khz or posedge rst) begin
        if (rst) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl};
            sda_q <= {sda_q[1:0], sda_in};
        end
    end

    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    assign sda_s     = sda_q[1];

endmodule

// File: rtl/i2c_slave_reg_responder.sv
// I2C target with a byte-wide register file, auto-incrementing pointer
// and open-drain SDA drive.
module i2c_slave_reg_responder
    import i2c_defs::*;
#(
    parameter logic [6:0] SLAVE_ADDR = SLAVE_ADDR_DEF,
    parameter int         ADDR_W     = 8
) (
    input  logic              clk_200khz,
    input  logic              rst,
    input  logic              scl,
    input  logic              sda_in,
    output logic              sda_oe,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic              rx_valid,
    output logic [ADDR_W-1:0] rx_addr,
    output logic [7:0]        rx_data,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] PTR_ONE = 1;

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync u_sync (
        .clk_200khz (clk_200khz),
        .rst        (rst),
        .scl        (scl),
        .sda_in     (sda_in),
        .scl_rise   (scl_rise),
        .scl_fall   (scl_fall),
        .start_det  (start_det),
        .stop_det   (stop_det),
        .sda_s      (sda_s)
    );

    bus_state_t        state;
    logic [7:0]        shreg;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] ptr;
    logic              rw;
    logic [7:0]        mem [2**ADDR_W];
    logic [7:0]        rx_byte;
    logic              bus_we;

    assign rx_byte = {shreg[6:0], sda_s};
    assign bus_we  = !start_det && !stop_det && state == WR_DATA
                     && scl_rise && cnt == 4'd7;

    // Bus write is issued last so it wins a same-index collision.
    always_ff @(posedge clk_200khz) begin
        if (host_we) mem[host_addr] <= host_wdata;
        if (bus_we)  mem[ptr]       <= rx_byte;
    end

    always_ff @(posedge clk_200khz or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sda_oe   <= 1'b0;
            rx_valid <= 1'b0;
            rx_addr  <= '0;
            rx_data  <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
            shreg    <= '0;
            cnt      <= '0;
            rw       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (start_det) begin
                cnt    <= '0;
                sda_oe <= 1'b0;
                state  <= ADDR;
            end else if (stop_det) begin
                sda_oe <= 1'b0;
                busy   <= 1'b0;
                state  <= IDLE;
            end else begin
                unique case (state)
                    IDLE: ;
                    ADDR: if (scl_rise) begin
                        shreg <= rx_byte;
                        cnt   <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt <= '0;
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                rw    <= rx_byte[0];
                                busy  <= 1'b1;
                                state <= ADDR_ACK;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                    REG_ADDR: if (scl_rise) begin
                        shreg <= rx_byte;
                        cnt   <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt   <= '0;
                            ptr   <= rx_byte[ADDR_W-1:0];
                            state <= REG_ACK;
                        end
                    end
                    WR_DATA: if (scl_rise) begin
                        shreg <= rx_byte;
                        cnt   <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt      <= '0;
                            rx_valid <= 1'b1;
                            rx_addr  <= ptr;
                            rx_data  <= rx_byte;
                            ptr      <= ptr + PTR_ONE;
                            state    <= WR_ACK;
                        end
                    end
                    // cnt marks whether the ACK is already being driven.
                    ADDR_ACK: if (scl_fall) begin
                        if (cnt == 4'd0) begin
                            sda_oe <= 1'b1;
                            cnt    <= 4'd1;
                        end else if (rw) begin
                            cnt    <= '0;
                            shreg  <= mem[ptr];
                            sda_oe <= ~mem[ptr][7];
                            state  <= RD_DATA;
                        end else begin
                            cnt    <= '0;
                            sda_oe <= 1'b0;
                            state  <= REG_ADDR;
                        end
                    end
                    REG_ACK, WR_ACK: if (scl_fall) begin
                        if (cnt == 4'd0) begin
                            sda_oe <= 1'b1;
                            cnt    <= 4'd1;
                        end else begin
                            cnt    <= '0;
                            sda_oe <= 1'b0;
                            state  <= WR_DATA;
                        end
                    end
                    RD_DATA: if (scl_rise) begin
                        cnt <= cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            cnt    <= '0;
                            sda_oe <= 1'b0;
                            ptr    <= ptr + PTR_ONE;
                            state  <= RD_ACK;
                        end else begin
                            shreg  <= {shreg[6:0], 1'b0};
                            sda_oe <= ~shreg[6];
                        end
                    end
                    RD_ACK: if (scl_rise) begin
                        if (sda_s) state <= IDLE;
                        else       cnt   <= 4'd1;
                    end else if (scl_fall && cnt != 4'd0) begin
                        cnt    <= '0;
                        shreg  <= mem[ptr];
                        sda_oe <= ~mem[ptr][7];
                        state  <= RD_DATA;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_reg_responder.sv
// Bench for the I2C register responder: 10 kHz master model, wired-AND
// SDA, reference register file and rx scoreboard.
`timescale 1ns/1ps
module tb_i2c_slave_reg_responder;

    localparam logic [6:0] SA = 7'h68;

    logic       clk_200khz = 1'b0;
    logic       rst;
    logic       scl;
    logic       sda_m;
    wire        sda_in;
    logic       sda_oe;
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       rx_valid;
    logic [7:0] rx_addr;
    logic [7:0] rx_data;
    logic       busy;

    assign sda_in = sda_m & ~sda_oe;

    always #2500 clk_200khz = ~clk_200khz;

    i2c_slave_reg_responder #(
        .SLAVE_ADDR (SA),
        .ADDR_W     (8)
    ) dut (
        .clk_200khz (clk_200khz),
        .rst        (rst),
        .scl        (scl),
        .sda_in     (sda_in),
        .sda_oe     (sda_oe),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .rx_valid   (rx_valid),
        .rx_addr    (rx_addr),
        .rx_data    (rx_data),
        .busy       (busy)
    );

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  mdl_mem [256];
    logic [7:0]  mdl_ptr;
    logic [15:0] exp_q [$];
    logic [7:0]  wq [$];
    int          oe_cnt = 0;
    int          busy_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk_200khz) begin
        if (sda_oe) oe_cnt++;
        if (busy) busy_cnt++;
        if (!rst && rx_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx_unexpected: got %0h/%0h want none",
                         rx_addr, rx_data);
            end else begin
                chk("rx_write", {rx_addr, rx_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic waitc(input int n);
        repeat (n) @(negedge clk_200khz);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; waitc(5);
        scl = 1'b1;   waitc(5);
        sda_m = 1'b0; waitc(5);
        scl = 1'b0;   waitc(5);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; waitc(5);
        scl = 1'b1;   waitc(5);
        sda_m = 1'b1; waitc(5);
    endtask

    task automatic wbit(input logic b);
        sda_m = b;  waitc(5);
        scl = 1'b1; waitc(10);
        scl = 1'b0; waitc(5);
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1; waitc(5);
        scl = 1'b1;   waitc(5);
        b = sda_in;   waitc(5);
        scl = 1'b0;   waitc(5);
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(ack);
    endtask

    task automatic rbyte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(nack);
    endtask

    task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        waitc(1);
        host_we = 1'b0;
        mdl_mem[a] = d;
    endtask

    // Sets the pointer to ra and writes every byte queued in wq.
    task automatic mwrite(input logic [7:0] ra);
        logic a;
        bus_start();
        wbyte({SA, 1'b0}, a); chk("addr_ack_w", a, 0);
        wbyte(ra, a);         chk("reg_ack", a, 0);
        mdl_ptr = ra;
        foreach (wq[i]) begin
            exp_q.push_back({mdl_ptr, wq[i]});
            mdl_mem[mdl_ptr] = wq[i];
            mdl_ptr++;
            wbyte(wq[i], a); chk("data_ack", a, 0);
        end
        chk("busy_mid", busy, 1);
        bus_stop();
        chk("busy_after_stop", busy, 0);
    endtask

    task automatic mread(input int n);
        logic       a;
        logic [7:0] d;
        bus_start();
        wbyte({SA, 1'b1}, a); chk("addr_ack_r", a, 0);
        for (int k = 0; k < n; k++) begin
            rbyte(k == n - 1, d);
            chk("rd_data", d, mdl_mem[mdl_ptr]);
            mdl_ptr++;
        end
        chk("rd_release", sda_oe, 0);
        bus_stop();
    endtask

    initial begin
        logic       a;
        logic [7:0] ra;
        int         n;
        rst = 1'b1; scl = 1'b1; sda_m = 1'b1;
        host_we = 1'b0; host_addr = '0; host_wdata = '0;
        waitc(3);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_addr", rx_addr, 0);
        chk("rst_rx_data", rx_data, 0);
        rst = 1'b0;
        mdl_ptr = '0;
        waitc(3);
        for (int i = 0; i < 256; i++)
            host_wr(i[7:0], 8'($urandom));

        wq = '{8'h5A};
        mwrite(8'h42);

        host_wr(8'h42, 8'hA5);
        wq = {};
        mwrite(8'h42);
        mread(1);

        oe_cnt = 0; busy_cnt = 0;
        bus_start();
        wbyte(8'hA0, a); chk("mismatch_nack", a, 1);
        wbyte(8'h55, a); chk("mismatch_nack2", a, 1);
        bus_stop();
        chk("mismatch_oe_cnt", oe_cnt, 0);
        chk("mismatch_busy_cnt", busy_cnt, 0);

        host_wr(8'hFE, 8'h11);
        host_wr(8'hFF, 8'h22);
        host_wr(8'h00, 8'h33);
        host_wr(8'h01, 8'h77);
        wq = {};
        mwrite(8'hFE);
        mread(3);
        mread(1);

        host_wr(8'h10, 8'h3C);
        bus_start();
        wbyte({SA, 1'b0}, a); chk("abort_addr_ack", a, 0);
        wbyte(8'h10, a);      chk("abort_reg_ack", a, 0);
        mdl_ptr = 8'h10;
        for (int i = 0; i < 4; i++) wbit(i[0]);
        bus_stop();
        chk("abort_busy", busy, 0);
        mread(1);

        // Host and bus write index 0x30 in the same cycle.
        wq = {};
        mwrite(8'h30);
        bus_start();
        wbyte({SA, 1'b0}, a); chk("col_addr_ack", a, 0);
        wbyte(8'h30, a);      chk("col_reg_ack", a, 0);
        mdl_ptr = 8'h30;
        exp_q.push_back({8'h30, 8'hC3});
        mdl_mem[8'h30] = 8'hC3;
        mdl_ptr++;
        for (int i = 7; i >= 1; i--) wbit(1'(8'hC3 >> i));
        sda_m = 1'b1; waitc(5);
        scl = 1'b1;   waitc(2);
        host_we = 1'b1; host_addr = 8'h30; host_wdata = 8'h3C;
        waitc(1);
        host_we = 1'b0;
        waitc(7);
        scl = 1'b0; waitc(5);
        rbit(a); chk("col_data_ack", a, 0);
        bus_stop();
        wq = {};
        mwrite(8'h30);
        mread(1);

        for (int it = 0; it < 6; it++) begin
            host_wr(8'($urandom), 8'($urandom));
            ra = 8'($urandom);
            n = $urandom_range(1, 3);
            wq = {};
            for (int j = 0; j < n; j++) wq.push_back(8'($urandom));
            mwrite(ra);
            wq = {};
            mwrite(ra);
            mread(n + $urandom_range(0, 1));
        end

        host_wr(8'h20, 8'h00);
        wq = {};
        mwrite(8'h20);
        bus_start();
        wbyte({SA, 1'b1}, a); chk("rst_rd_ack", a, 0);
        for (int i = 0; i < 3; i++) begin
            rbit(a); chk("rst_rd_bit", a, 0);
        end
        chk("oe_before_rst", sda_oe, 1);
        rst = 1'b1;
        #1;
        chk("oe_async_rst", sda_oe, 0);
        waitc(2);
        rst = 1'b0;
        mdl_ptr = '0;
        waitc(2);
        bus_stop();
        bus_start();
        wbyte({SA, 1'b0}, a); chk("post_rst_ack", a, 0);
        bus_stop();

        waitc(5);
        chk("rx_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
